pixel_state_machine: RTL and testbench

- Frame sequencer for the pixel array.
- Generates the ERASE, EXPOSE and READ phase controls consumed by every pixel sensor.
- Drives the 8-bit conversion count that the top level places on the shared pixel DATA bus while the ramp runs, so pixel latches capture the count at which their comparator trips.
- Sits directly upstream of the pixel sensors; one instance per array.

---
 rtl/pixel_state_machine.sv | 172 +++++++++++++++++
 tb/tb_pixel_state_machine.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_state_machine.sv
// Frame sequencer for the pixel array.
// Walks IDLE -> ERASE -> EXPOSE -> CONVERT -> READ (row by row) -> IDLE and
// produces the phase controls consumed by every pixel sensor, plus the 8-bit
// conversion count that the top level drives onto the shared DATA bus while
// the ramp runs.
//
// Ports:
//   clk         system clock, all state on the rising edge
//   reset       asynchronous active-low reset
//   start       frame request, sampled only in IDLE
//   erase       pixel erase phase
//   expose      pixel exposure phase
//   convert     conversion phase (ramp and DATA bus drive enabled)
//   data        conversion count, 0 outside CONVERT, saturates at 255
//   read        one-hot row read select
//   row_valid   one-cycle pulse on the last read cycle of each row
//   busy        high in every state except IDLE
//   frame_done  one-cycle pulse when the frame completes
module pixel_state_machine #(
  parameter int unsigned ERASE_CYC  = 5,
  parameter int unsigned EXPOSE_CYC = 255,
  parameter int unsigned CONV_CYC   = 256,
  parameter int unsigned N_ROWS     = 2,
  parameter int unsigned READ_CYC   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              erase,
  output logic              expose,
  output logic              convert,
  output logic [7:0]        data,
  output logic [N_ROWS-1:0] read,
  output logic              row_valid,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned ROW_W  = 4;
  localparam int unsigned DATA_W = 8;

  // Terminal counts: the phase counter runs 0..CYC-1 in every phase.
  localparam logic [CNT_W-1:0]  ERASE_LAST  = CNT_W'(ERASE_CYC - 1);
  localparam logic [CNT_W-1:0]  EXPOSE_LAST = CNT_W'(EXPOSE_CYC - 1);
  localparam logic [CNT_W-1:0]  CONV_LAST   = CNT_W'(CONV_CYC - 1);
  localparam logic [CNT_W-1:0]  READ_LAST   = CNT_W'(READ_CYC - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST    = ROW_W'(N_ROWS - 1);
  localparam logic [DATA_W-1:0] DATA_MAX    = '1;

  // With a single-cycle read window the first cycle of a row is also its last.
  localparam logic RV_ON_ENTRY = (READ_CYC == 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERASE,
    S_EXPOSE,
    S_CONVERT,
    S_READ
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [ROW_W-1:0] row;

  // Sequencer: state, counters and all Moore outputs share one register block.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      row        <= '0;
      erase      <= 1'b0;
      expose     <= 1'b0;
      convert    <= 1'b0;
      data       <= '0;
      read       <= '0;
      row_valid  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      // Pulses default low; only the cycle that needs them raises them.
      row_valid  <= 1'b0;
      frame_done <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_ERASE;
            cnt   <= '0;
            erase <= 1'b1;
            busy  <= 1'b1;
          end
        end

        S_ERASE: begin
          if (cnt == ERASE_LAST) begin
            state  <= S_EXPOSE;
            cnt    <= '0;
            erase  <= 1'b0;
            expose <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_EXPOSE: begin
          if (cnt == EXPOSE_LAST) begin
            state   <= S_CONVERT;
            cnt     <= '0;
            expose  <= 1'b0;
            convert <= 1'b1;
            data    <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_CONVERT: begin
          if (cnt == CONV_LAST) begin
            state     <= S_READ;
            cnt       <= '0;
            row       <= '0;
            convert   <= 1'b0;
            data      <= '0;
            read      <= N_ROWS'(1);
            row_valid <= RV_ON_ENTRY;
          end else begin
            cnt <= cnt + CNT_W'(1);
            // Long conversions hold the top code rather than wrapping to 0.
            if (data != DATA_MAX) begin
              data <= data + DATA_W'(1);
            end
          end
        end

        S_READ: begin
          if (cnt == READ_LAST) begin
            cnt <= '0;
            if (row == ROW_LAST) begin
              state      <= S_IDLE;
              row        <= '0;
              read       <= '0;
              busy       <= 1'b0;
              frame_done <= 1'b1;
            end else begin
              // Next row starts immediately: walk the one-hot select up.
              row       <= row + ROW_W'(1);
              read      <= read << 1;
              row_valid <= RV_ON_ENTRY;
            end
          end else begin
            cnt       <= cnt + CNT_W'(1);
            row_valid <= ((cnt + CNT_W'(1)) == READ_LAST);
          end
        end

        default: begin
          state      <= S_IDLE;
          cnt        <= '0;
          row        <= '0;
          erase      <= 1'b0;
          expose     <= 1'b0;
          convert    <= 1'b0;
          data       <= '0;
          read       <= '0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_state_machine.sv
// Directed bench for pixel_state_machine: default, saturating-conversion and
// single-row instances sharing one clock, plus a behavioural pixel for the
// single-row instance.
module tb_pixel_state_machine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Default instance.
  logic       rst_def = 1'b0, st_def = 1'b0;
  logic       d_erase, d_expose, d_convert, d_rv, d_busy, d_fd;
  logic [7:0] d_data;
  logic [1:0] d_read;

  pixel_state_machine u_def (
    .clk(clk), .reset(rst_def), .start(st_def),
    .erase(d_erase), .expose(d_expose), .convert(d_convert), .data(d_data),
    .read(d_read), .row_valid(d_rv), .busy(d_busy), .frame_done(d_fd)
  );

  // Conversion longer than the 8-bit count range.
  logic       rst_sat = 1'b0, st_sat = 1'b0;
  logic       s_erase, s_expose, s_convert, s_rv, s_busy, s_fd;
  logic [7:0] s_data;
  logic [1:0] s_read;

  pixel_state_machine #(.CONV_CYC(300)) u_sat (
    .clk(clk), .reset(rst_sat), .start(st_sat),
    .erase(s_erase), .expose(s_expose), .convert(s_convert), .data(s_data),
    .read(s_read), .row_valid(s_rv), .busy(s_busy), .frame_done(s_fd)
  );

  // Single-row instance driving the pixel model.
  logic       rst_pix = 1'b0, st_pix = 1'b0;
  logic       p_erase, p_expose, p_convert, p_rv, p_busy, p_fd;
  logic [7:0] p_data;
  logic [0:0] p_read;

  pixel_state_machine #(.N_ROWS(1)) u_pix (
    .clk(clk), .reset(rst_pix), .start(st_pix),
    .erase(p_erase), .expose(p_expose), .convert(p_convert), .data(p_data),
    .read(p_read), .row_valid(p_rv), .busy(p_busy), .frame_done(p_fd)
  );

  logic [15:0] obs_def, obs_sat;
  assign obs_def = {d_erase, d_expose, d_convert, d_data, d_read, d_rv, d_busy, d_fd};
  assign obs_sat = {s_erase, s_expose, s_convert, s_data, s_read, s_rv, s_busy, s_fd};

  // At most one phase control may be high in any cycle.
  always @(negedge clk) begin
    assert ($onehot0({d_erase, d_expose, d_convert, d_read}))
      else $error("exclusivity violated on default instance");
    assert ($onehot0({s_erase, s_expose, s_convert, s_read}))
      else $error("exclusivity violated on saturating instance");
    assert ($onehot0({p_erase, p_expose, p_convert, p_read}))
      else $error("exclusivity violated on single-row instance");
  end

  // Hand-derived frame schedule for a 2-row, 5/255/conv/5 frame; t = cycles
  // after the edge that sampled start.
  function automatic logic [15:0] exp_vec(input int t, input int conv);
    logic e, x, c, rv, b, fd;
    logic [7:0] d;
    logic [1:0] r;
    int cc;
    e = 0; x = 0; c = 0; rv = 0; d = 8'd0; r = 2'b00;
    cc = 260 + conv;
    if (t < 5) e = 1;
    else if (t < 260) x = 1;
    else if (t < cc) begin
      c = 1;
      d = (t - 260 > 255) ? 8'd255 : 8'(t - 260);
    end else if (t < cc + 5) begin
      r = 2'b01; rv = (t == cc + 4);
    end else if (t < cc + 10) begin
      r = 2'b10; rv = (t == cc + 9);
    end
    b  = (t < cc + 10);
    fd = (t == cc + 10);
    return {e, x, c, d, r, rv, b, fd};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step();
    vectors++;
    if ({obs_def, obs_sat} !== 32'd0 || {p_erase, p_expose, p_convert, p_data, p_read, p_rv, p_busy, p_fd} !== 15'd0) begin
      miscompares++;
      $display("FAIL reset_hold got def=%h sat=%h exp=0", obs_def, obs_sat);
    end
    rst_def = 1'b1; rst_sat = 1'b1; rst_pix = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      vectors++;
      if (obs_def !== 16'd0 || obs_sat !== 16'd0) begin
        miscompares++;
        $display("FAIL idle_no_start cyc=%0d got def=%h sat=%h exp=0", i, obs_def, obs_sat);
      end
    end
  endtask

  task automatic test_single_frame();
    st_def = 1'b1;
    step();
    st_def = 1'b0;
    for (int t = 0; t <= 530; t++) begin
      vectors++;
      if (obs_def !== exp_vec(t, 256)) begin
        miscompares++;
        $display("FAIL single_frame t=%0d got=%h exp=%h", t, obs_def, exp_vec(t, 256));
      end
      // Start pulse mid-conversion must be ignored.
      st_def = (t == 299);
      step();
    end
    st_def = 1'b0;
  endtask

  task automatic test_back_to_back();
    st_def = 1'b1;
    step();
    for (int t = 0; t <= 1100; t++) begin
      vectors++;
      if (obs_def !== exp_vec(t % 527, 256)) begin
        miscompares++;
        $display("FAIL back_to_back t=%0d got=%h exp=%h", t, obs_def, exp_vec(t % 527, 256));
      end
      step();
    end
    st_def = 1'b0;
  endtask

  task automatic test_saturation();
    st_sat = 1'b1;
    step();
    st_sat = 1'b0;
    for (int t = 0; t <= 575; t++) begin
      vectors++;
      if (obs_sat !== exp_vec(t, 300)) begin
        miscompares++;
        $display("FAIL saturation t=%0d got=%h exp=%h", t, obs_sat, exp_vec(t, 300));
      end
      step();
    end
  endtask

  task automatic test_reset_mid_frame();
    rst_def = 1'b0;
    step();
    rst_def = 1'b1;
    step();
    st_def = 1'b1;
    step();
    st_def = 1'b0;
    for (int t = 0; t < 360; t++) step();
    vectors++;
    if (d_convert !== 1'b1 || d_data !== 8'd100) begin
      miscompares++;
      $display("FAIL pre_abort got convert=%b data=%0d exp convert=1 data=100", d_convert, d_data);
    end
    #2 rst_def = 1'b0;
    #1;
    vectors++;
    if (obs_def !== 16'd0) begin
      miscompares++;
      $display("FAIL async_reset got=%h exp=0", obs_def);
    end
    step();
    rst_def = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (obs_def !== 16'd0) begin
        miscompares++;
        $display("FAIL post_abort_idle cyc=%0d got=%h exp=0", i, obs_def);
      end
    end
    st_def = 1'b1;
    step();
    st_def = 1'b0;
    for (int t = 0; t <= 530; t++) begin
      vectors++;
      if (obs_def !== exp_vec(t, 256)) begin
        miscompares++;
        $display("FAIL fresh_frame t=%0d got=%h exp=%h", t, obs_def, exp_vec(t, 256));
      end
      step();
    end
  endtask

  task automatic test_pixel();
    real    v;
    logic   tripped;
    logic [7:0] latch, bus, captured;
    int     n_exp, n_rv, fd_t;
    v = 0.0; tripped = 1'b0; latch = 8'd0; captured = 8'd0;
    n_exp = 0; n_rv = 0; fd_t = -1;
    st_pix = 1'b1;
    step();
    st_pix = 1'b0;
    for (int t = 0; t <= 525; t++) begin
      // Pixel integrates 0.5 per exposure cycle; latch follows the count
      // until the ramp reaches the pixel voltage.
      if (p_expose) begin
        v = v + 0.5;
        n_exp++;
      end
      if (p_convert && !tripped) begin
        latch = p_data;
        if (real'(p_data) >= v) tripped = 1'b1;
      end
      bus = p_convert ? p_data : (p_read[0] ? latch : 8'd0);
      if (p_rv) begin
        captured = bus;
        n_rv++;
      end
      if (p_fd) fd_t = t;
      step();
    end
    vectors++;
    if (n_exp != 255) begin
      miscompares++;
      $display("FAIL pixel_expose_len got=%0d exp=255", n_exp);
    end
    vectors++;
    if (n_rv != 1) begin
      miscompares++;
      $display("FAIL pixel_row_valid_count got=%0d exp=1", n_rv);
    end
    vectors++;
    if (fd_t != 521) begin
      miscompares++;
      $display("FAIL pixel_frame_done_time got=%0d exp=521", fd_t);
    end
    vectors++;
    if (captured < 8'd127 || captured > 8'd129) begin
      miscompares++;
      $display("FAIL pixel_readback got=%0d exp=128+-1", captured);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_saturation();
    test_reset_mid_frame();
    test_pixel();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
